// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for mem_access_unit: access widths, FSM states and byte-lane masks.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MW_NONE = 3'b000,
    MW_D    = 3'b001,
    MW_W    = 3'b010,
    MW_H    = 3'b011,
    MW_B    = 3'b100,
    MW_WU   = 3'b101,
    MW_HU   = 3'b110,
    MW_BU   = 3'b111
  } memdata_width_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } mau_state_t;

  localparam logic [7:0] LANE_MASK_B = 8'h01;
  localparam logic [7:0] LANE_MASK_H = 8'h03;
  localparam logic [7:0] LANE_MASK_W = 8'h0F;
  localparam logic [7:0] LANE_MASK_D = 8'hFF;

  // Unaligned byte-lane mask for an access width; shifted by the lane offset at use.
  function automatic logic [7:0] lane_mask(input memdata_width_t width);
    case (width)
      MW_B, MW_BU: return LANE_MASK_B;
      MW_H, MW_HU: return LANE_MASK_H;
      MW_W, MW_WU: return LANE_MASK_W;
      MW_D:        return LANE_MASK_D;
      default:     return 8'h00;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  // Signed and unsigned variants of a size share the same alignment rule.
  function automatic logic [2:0] align_bits(input memdata_width_t width);
    case (width)
      MW_H, MW_HU: return 3'b001;
      MW_W, MW_WU: return 3'b011;
      MW_D:        return 3'b111;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_extend.sv
// Combinational load path: picks the addressed bytes out of a doubleword and
// sign- or zero-extends them to 64 bits according to the access width.
module mem_lane_extend
  import mem_access_unit_pkg::*;
(
  input  memdata_width_t width,
  input  logic [2:0]     offset,
  input  logic [63:0]    dword,
  output logic [63:0]    data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = dword >> {offset, 3'b000};
    data    = '0;
    case (width)
      MW_D:    data = shifted;
      MW_W:    data = {{32{shifted[31]}}, shifted[31:0]};
      MW_WU:   data = {32'b0, shifted[31:0]};
      MW_H:    data = {{48{shifted[15]}}, shifted[15:0]};
      MW_HU:   data = {48'b0, shifted[15:0]};
      MW_B:    data = {{56{shifted[7]}}, shifted[7:0]};
      MW_BU:   data = {56'b0, shifted[7:0]};
      MW_NONE: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit bridging one pipeline access to a single-beat 64-bit memory port.
// Optional MEM_MISALIGN_CHECK_EN: fault misaligned H/W/D accesses instead of aligning them down.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we_mem,
  input  logic        re_mem,
  input  logic [2:0]  memdata_width,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        resp_valid,
  output logic [63:0] rdata,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wstrb,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid pulses once per accepted request.
  mau_state_t     state_q, state_d;
  memdata_width_t width_in, width_q;
  logic           accept, op_ok, fault_in, go_mem;
  logic [2:0]     off_in, off_q;
  logic [63:3]    addr_q;
  logic [63:0]    wdata_q, rdata_q, load_data;
  logic           we_q, misalign_q;

  assign width_in  = memdata_width_t'(memdata_width);
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign op_ok     = (we_mem ^ re_mem) && (width_in != MW_NONE);

`ifdef MEM_MISALIGN_CHECK_EN
  assign fault_in = (addr[2:0] & align_bits(width_in)) != 3'b000;
  assign off_in   = addr[2:0];
`else
  // Without the check, misaligned accesses are silently aligned down to their size.
  assign fault_in = 1'b0;
  assign off_in   = addr[2:0] & ~align_bits(width_in);
`endif

  assign go_mem = op_ok && !fault_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      width_q    <= MW_NONE;
      addr_q     <= '0;
      off_q      <= 3'b000;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else if (accept) begin
      we_q       <= we_mem;
      width_q    <= width_in;
      addr_q     <= addr[63:3];
      off_q      <= off_in;
      wdata_q    <= wdata;
      misalign_q <= fault_in;
      rdata_q    <= '0;
    end else if ((state_q == ST_REQ) && mem_ack) begin
      rdata_q <= we_q ? 64'h0 : load_data;
    end
  end

  mem_lane_extend u_lane_extend (
    .width  (width_q),
    .offset (off_q),
    .dword  (mem_rdata),
    .data   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    resp_valid = 1'b0;
    rdata      = '0;
    misalign   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wstrb  = 8'h00;
    mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = go_mem ? ST_REQ : ST_RESP;
      end
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = {addr_q, 3'b000};
        if (we_q) begin
          mem_wstrb = lane_mask(width_q) << off_q;
          mem_wdata = wdata_q << {off_q, 3'b000};
        end
        if (mem_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        rdata      = rdata_q;
        misalign   = misalign_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed load/store tables, alignment,
// illegal requests, reset mid-access and a random scoreboarded sequence.
module tb_mem_access_unit;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, we_mem, re_mem;
  logic [2:0]  memdata_width;
  logic [63:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, misalign, mem_req, mem_we, mem_ack;
  logic [7:0]  mem_wstrb;

  int vectors = 0;
  int miscompares = 0;
  logic [64:0] exp_q[$];

  // observations collected by the driver
  int          obs_lat, obs_mreq_cycles;
  logic [64:0] obs_resp;
  logic [63:0] obs_addr, obs_wdata;
  logic [7:0]  obs_wstrb;
  logic        obs_we, obs_ready, obs_after, obs_unstable;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .we_mem(we_mem), .re_mem(re_mem), .memdata_width(memdata_width),
    .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata),
    .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] w);
    case (w)
      3'b001:        return 8;
      3'b010, 3'b101: return 4;
      3'b011, 3'b110: return 2;
      3'b100, 3'b111: return 1;
      default:       return 0;
    endcase
  endfunction

  function automatic bit is_signed_w(input logic [2:0] w);
    return (w == 3'b010) || (w == 3'b011) || (w == 3'b100);
  endfunction

  function automatic bit model_fault(input logic [2:0] w, input logic [63:0] a);
    return CHECK_EN && (size_of(w) > 1) && ((int'(a[2:0]) % size_of(w)) != 0);
  endfunction

  function automatic int model_off(input logic [2:0] w, input logic [63:0] a);
    int lo;
    lo = int'(a[2:0]);
    if (size_of(w) > 1) lo = lo - (lo % size_of(w));
    return lo;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] w, input logic [63:0] a,
                                             input logic [63:0] md);
    logic [63:0] v;
    int s, o;
    s = size_of(w);
    o = model_off(w, a);
    v = '0;
    for (int i = 0; i < s; i++) v[8*i +: 8] = md[8*(o+i) +: 8];
    if (is_signed_w(w) && v[8*s-1])
      for (int i = 8*s; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] w, input logic [63:0] a);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < size_of(w); i++) m[model_off(w, a) + i] = 1'b1;
    return m;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with the unit idle; returns at a falling edge.
  task automatic drive_access(input logic we, input logic re, input logic [2:0] w,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] md, input int waits);
    int cyc, n;
    bit done;
    obs_ready = req_ready;
    obs_lat = -1; obs_resp = '0; obs_addr = '0; obs_wstrb = 8'h00; obs_wdata = '0;
    obs_we = 1'b0; obs_mreq_cycles = 0; obs_unstable = 1'b0; obs_after = 1'b0;
    req_valid = 1'b1; we_mem = we; re_mem = re; memdata_width = w; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; we_mem = 1'b0; re_mem = 1'b0; memdata_width = 3'b000;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    cyc = 0; n = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_req === 1'b1) begin
        if (obs_mreq_cycles == 0) begin
          obs_addr = mem_addr; obs_wstrb = mem_wstrb; obs_wdata = mem_wdata; obs_we = mem_we;
        end else if (mem_addr !== obs_addr || mem_wstrb !== obs_wstrb ||
                     mem_wdata !== obs_wdata || mem_we !== obs_we) begin
          obs_unstable = 1'b1;
        end
        obs_mreq_cycles++;
        if (n >= waits) begin
          mem_ack = 1'b1;
          mem_rdata = md;
        end
        n++;
      end
      if (resp_valid === 1'b1) begin
        obs_lat = cyc;
        obs_resp = {misalign, rdata};
        done = 1'b1;
      end
    end
    mem_ack = 1'b0;
    @(negedge clk);
    obs_after = resp_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: ready/mem_req/resp_valid=%b%b%b required 000", req_ready, mem_req, resp_valid);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({req_ready, mem_req, mem_we, resp_valid, misalign} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready,mem_req,mem_we,resp_valid,misalign=%b required 10000",
               {req_ready, mem_req, mem_we, resp_valid, misalign});
    end
    vectors++;
    if (rdata !== 64'h0 || mem_addr !== 64'h0 || mem_wstrb !== 8'h00 || mem_wdata !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h wstrb=%h wdata=%h required all 0",
               rdata, mem_addr, mem_wstrb, mem_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_load_extend;
    logic [2:0]  t_w[7];
    logic [63:0] t_a[7], t_md[7], t_exp[7];
    int          t_wt[7];
    logic [64:0] exp;
    t_w   = '{3'b010, 3'b111, 3'b011, 3'b110, 3'b100, 3'b001, 3'b101};
    t_a   = '{64'h2004, 64'h2007, 64'h2002, 64'h2006, 64'h2003, 64'h2008, 64'h2000};
    t_md  = '{64'h8000_0000_0000_0000, 64'hAB00_0000_0000_0000, 64'h0000_0000_8001_0000,
              64'hFFFE_0000_0000_0000, 64'h0000_0000_7F00_0000, 64'h0123_4567_89AB_CDEF,
              64'h1111_1111_F00D_CAFE};
    t_exp = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_00AB, 64'hFFFF_FFFF_FFFF_8001,
              64'h0000_0000_0000_FFFE, 64'h0000_0000_0000_007F, 64'h0123_4567_89AB_CDEF,
              64'h0000_0000_F00D_CAFE};
    t_wt  = '{0, 1, 0, 2, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({1'b0, t_exp[i]});
      drive_access(1'b0, 1'b1, t_w[i], t_a[i], 64'h0, t_md[i], t_wt[i]);
      exp = exp_q.pop_front();
      vectors++;
      if (obs_resp !== exp) begin
        miscompares++;
        $display("FAIL load_data[%0d]: misalign,rdata=%h required %h", i, obs_resp, exp);
      end
      vectors++;
      if (obs_lat !== t_wt[i] + 2) begin
        miscompares++;
        $display("FAIL load_latency[%0d]: %0d cycles required %0d", i, obs_lat, t_wt[i] + 2);
      end
      vectors++;
      if (obs_ready !== 1'b1 || obs_after !== 1'b0) begin
        miscompares++;
        $display("FAIL load_handshake[%0d]: ready=%b resp_after=%b required 1/0", i, obs_ready, obs_after);
      end
      vectors++;
      if (obs_we !== 1'b0 || obs_wstrb !== 8'h00 || obs_addr !== {t_a[i][63:3], 3'b000} || obs_unstable !== 1'b0) begin
        miscompares++;
        $display("FAIL load_port[%0d]: we=%b wstrb=%h addr=%h unstable=%b required 0/00/%h/0",
                 i, obs_we, obs_wstrb, obs_addr, obs_unstable, {t_a[i][63:3], 3'b000});
      end
    end
  endtask

  task automatic test_store_lanes;
    logic [2:0]  t_w[4];
    logic [63:0] t_a[4], t_wd[4], t_ewd[4], t_ea[4];
    logic [7:0]  t_es[4];
    int          t_wt[4];
    logic [64:0] exp;
    t_w   = '{3'b011, 3'b010, 3'b100, 3'b001};
    t_a   = '{64'h3002, 64'h1004, 64'h4005, 64'h4008};
    t_wd  = '{64'h1234, 64'hCAFE_F00D, 64'h5A, 64'h0123_4567_89AB_CDEF};
    t_es  = '{8'h0C, 8'hF0, 8'h20, 8'hFF};
    t_ewd = '{64'h0000_0000_1234_0000, 64'hCAFE_F00D_0000_0000, 64'h0000_5A00_0000_0000,
              64'h0123_4567_89AB_CDEF};
    t_ea  = '{64'h3000, 64'h1000, 64'h4000, 64'h4008};
    t_wt  = '{3, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(65'h0);
      drive_access(1'b1, 1'b0, t_w[i], t_a[i], t_wd[i], {$urandom, $urandom}, t_wt[i]);
      exp = exp_q.pop_front();
      vectors++;
      if (obs_resp !== exp || obs_lat !== t_wt[i] + 2) begin
        miscompares++;
        $display("FAIL store_resp[%0d]: misalign,rdata=%h lat=%0d required %h lat=%0d",
                 i, obs_resp, obs_lat, exp, t_wt[i] + 2);
      end
      vectors++;
      if (obs_wstrb !== t_es[i] || obs_wdata !== t_ewd[i]) begin
        miscompares++;
        $display("FAIL store_lanes[%0d]: wstrb=%h wdata=%h required %h %h",
                 i, obs_wstrb, obs_wdata, t_es[i], t_ewd[i]);
      end
      vectors++;
      if (obs_addr !== t_ea[i] || obs_we !== 1'b1 || obs_unstable !== 1'b0 || obs_mreq_cycles !== t_wt[i] + 1) begin
        miscompares++;
        $display("FAIL store_port[%0d]: addr=%h we=%b unstable=%b req_cycles=%0d required %h 1 0 %0d",
                 i, obs_addr, obs_we, obs_unstable, obs_mreq_cycles, t_ea[i], t_wt[i] + 1);
      end
    end
  endtask

  task automatic test_misalign;
    logic [64:0] exp_sw, exp_ld, got;
    logic [7:0]  exp_strb;
    int          exp_lat;
`ifdef MEM_MISALIGN_CHECK_EN
    exp_sw = {1'b1, 64'h0};
    exp_ld = {1'b1, 64'h0};
    exp_strb = 8'h00;
    exp_lat = 1;
`else
    exp_sw = 65'h0;
    exp_ld = {1'b0, 64'h8877_6655_4433_2211};
    exp_strb = 8'h0F;
    exp_lat = 2;
`endif
    exp_q.push_back(exp_sw);
    drive_access(1'b1, 1'b0, 3'b010, 64'h3001, 64'hDEAD_BEEF, 64'h0, 0);
    got = exp_q.pop_front();
    vectors++;
    if (obs_resp !== got || obs_lat !== exp_lat) begin
      miscompares++;
      $display("FAIL misalign_sw: misalign,rdata=%h lat=%0d required %h lat=%0d", obs_resp, obs_lat, got, exp_lat);
    end
    vectors++;
    if (obs_wstrb !== exp_strb) begin
      miscompares++;
      $display("FAIL misalign_sw_strb: wstrb=%h required %h", obs_wstrb, exp_strb);
    end
    exp_q.push_back(exp_ld);
    drive_access(1'b0, 1'b1, 3'b001, 64'h3005, 64'h0, 64'h8877_6655_4433_2211, 0);
    got = exp_q.pop_front();
    vectors++;
    if (obs_resp !== got || obs_lat !== exp_lat) begin
      miscompares++;
      $display("FAIL misalign_ld: misalign,rdata=%h lat=%0d required %h lat=%0d", obs_resp, obs_lat, got, exp_lat);
    end
  endtask

  task automatic test_illegal;
    logic        t_we[3], t_re[3];
    logic [2:0]  t_w[3];
    logic [64:0] got;
    t_we = '{1'b1, 1'b0, 1'b0};
    t_re = '{1'b1, 1'b0, 1'b1};
    t_w  = '{3'b010, 3'b001, 3'b000};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(65'h0);
      drive_access(t_we[i], t_re[i], t_w[i], 64'h7000, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      got = exp_q.pop_front();
      vectors++;
      if (obs_resp !== got || obs_lat !== 1 || obs_mreq_cycles !== 0) begin
        miscompares++;
        $display("FAIL illegal[%0d]: misalign,rdata=%h lat=%0d req_cycles=%0d required %h lat=1 req_cycles=0",
                 i, obs_resp, obs_lat, obs_mreq_cycles, got);
      end
    end
  endtask

  task automatic test_ack_ignored;
    bit bad;
    logic [64:0] got;
    bad = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    mem_ack = 1'b0;
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_idle: spurious activity=%b required 0", bad);
    end
    exp_q.push_back({1'b0, 64'h0000_0000_1234_5678});
    drive_access(1'b0, 1'b1, 3'b010, 64'h6000, 64'h0, 64'hFFFF_FFFF_1234_5678, 0);
    got = exp_q.pop_front();
    vectors++;
    if (obs_resp !== got || obs_lat !== 2) begin
      miscompares++;
      $display("FAIL ack_idle_load: misalign,rdata=%h lat=%0d required %h lat=2", obs_resp, obs_lat, got);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  w;
    logic [63:0] a, wd, md;
    logic        we, re, mem_cyc, flt;
    int          op, waits, exp_lat;
    logic [7:0]  exp_strb;
    logic [64:0] got;
    for (int i = 0; i < 24; i++) begin
      w = 3'($urandom_range(0, 7));
      op = $urandom_range(0, 4);
      we = (op == 2) || (op == 3);
      re = (op <= 1) || (op == 3);
      a = {$urandom, $urandom}; wd = {$urandom, $urandom}; md = {$urandom, $urandom};
      waits = $urandom_range(0, 3);
      flt = model_fault(w, a);
      mem_cyc = (we ^ re) && (w != 3'b000) && !flt;
      exp_lat = mem_cyc ? waits + 2 : 1;
      exp_strb = (mem_cyc && we) ? model_strb(w, a) : 8'h00;
      exp_q.push_back({flt, (mem_cyc && re) ? model_load(w, a, md) : 64'h0});
      drive_access(we, re, w, a, wd, md, waits);
      got = exp_q.pop_front();
      vectors++;
      if (obs_resp !== got || obs_lat !== exp_lat || obs_after !== 1'b0) begin
        miscompares++;
        $display("FAIL random[%0d]: w=%0d a=%h misalign,rdata=%h lat=%0d required %h lat=%0d",
                 i, w, a, obs_resp, obs_lat, got, exp_lat);
      end
      vectors++;
      if (obs_wstrb !== exp_strb || obs_addr !== (mem_cyc ? {a[63:3], 3'b000} : 64'h0)) begin
        miscompares++;
        $display("FAIL random_port[%0d]: wstrb=%h addr=%h required %h %h",
                 i, obs_wstrb, obs_addr, exp_strb, mem_cyc ? {a[63:3], 3'b000} : 64'h0);
      end
      if (mem_cyc && we) begin
        vectors++;
        if (obs_wdata !== (wd << (8 * model_off(w, a)))) begin
          miscompares++;
          $display("FAIL random_wdata[%0d]: wdata=%h required %h", i, obs_wdata, wd << (8 * model_off(w, a)));
        end
      end
    end
  endtask

  task automatic test_reset_in_req;
    bit seen;
    logic [64:0] got;
    req_valid = 1'b1; re_mem = 1'b1; we_mem = 1'b0; memdata_width = 3'b001; addr = 64'h5000;
    @(posedge clk); #1;
    req_valid = 1'b0; re_mem = 1'b0; memdata_width = 3'b000;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_req_enter: mem_req=%b required 1", mem_req);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_req_drop: mem_req/ready/resp_valid=%b%b%b required 000", mem_req, req_ready, resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_req_quiet: activity after reset=%b required 0", seen);
    end
    exp_q.push_back({1'b0, 64'h0F0F_1234_5678_F0F0});
    drive_access(1'b0, 1'b1, 3'b001, 64'h5008, 64'h0, 64'h0F0F_1234_5678_F0F0, 0);
    got = exp_q.pop_front();
    vectors++;
    if (obs_resp !== got || obs_lat !== 2 || obs_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_req_next: misalign,rdata=%h lat=%0d ready=%b required %h lat=2 ready=1",
               obs_resp, obs_lat, obs_ready, got);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; we_mem = 1'b0; re_mem = 1'b0; memdata_width = 3'b000;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_load_extend();
    test_store_lanes();
    test_misalign();
    test_illegal();
    test_ack_ignored();
    test_back_to_back();
    test_reset_in_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
